// File: rtl/vrf_stream_ctrl.sv
// Streams bursts of vector registers between valid/ready data ports and a
// register file with single-cycle write and one-cycle-latency read access.
//
// state | meaning
// IDLE  | waiting for a command; zero-length commands complete here
// WRITE | one register write per accepted wdata beat
// READ  | issuing reads, throttled so at most two beats are ever pending
// DRAIN | all reads issued; waiting for the final beat to leave on rdata
module vrf_stream_ctrl #(
  parameter int NUM_ELEMS           = 8,
  parameter int ELEM_SIZE           = 16,
  parameter int ENABLES_PER_ELEMENT = 4,
  parameter int VRF_SIZE            = 32,
  localparam int AW = $clog2(VRF_SIZE),
  localparam int DW = NUM_ELEMS * ELEM_SIZE,
  localparam int MW = NUM_ELEMS * ENABLES_PER_ELEMENT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_base,
  input  logic [AW:0]   cmd_count,
  input  logic [MW-1:0] cmd_mask,
  input  logic          wdata_valid,
  output logic          wdata_ready,
  input  logic [DW-1:0] wdata,
  output logic          rdata_valid,
  input  logic          rdata_ready,
  output logic [DW-1:0] rdata,
  output logic          rdata_last,
  output logic          done,
  output logic          vrf_en,
  output logic          vrf_we,
  output logic [AW-1:0] vrf_addr,
  output logic [MW-1:0] vrf_write_mask,
  output logic [DW-1:0] vrf_data_w,
  input  logic [DW-1:0] vrf_data_r
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, addr_inc;
  logic [AW:0]   remain_q, remain_d;
  logic [MW-1:0] mask_q, mask_d;
  logic          done_q, done_d;
  logic          inflight_q;

  logic [DW-1:0] fifo_mem [2];
  logic          fifo_wr_q, fifo_rd_q;
  logic [1:0]    fifo_cnt_q;
  logic [1:0]    outstanding;

  logic accept, wr_hs, rd_issue, pop, bypass, push, pop_fifo, final_beat;

  assign cmd_ready   = (state_q == IDLE);
  assign accept      = cmd_valid & cmd_ready;
  assign wdata_ready = (state_q == WRITE) & ~reset;
  assign wr_hs       = wdata_valid & wdata_ready;

  // Beats owed to the consumer: already buffered plus the read returning now.
  assign outstanding = fifo_cnt_q + {1'b0, inflight_q};
  assign rd_issue    = (state_q == READ) & ~reset & (outstanding < 2'd2);

  assign addr_inc = (addr_q == AW'(VRF_SIZE - 1)) ? '0 : addr_q + AW'(1);

  // Returning read data falls straight through to rdata when the buffer is
  // empty, which gives the two-cycle first-beat latency and full throughput.
  assign rdata_valid = ((fifo_cnt_q != 2'd0) | inflight_q) & ~reset;
  assign pop         = rdata_valid & rdata_ready;
  assign pop_fifo    = pop & (fifo_cnt_q != 2'd0);
  assign bypass      = pop & (fifo_cnt_q == 2'd0);
  assign push        = inflight_q & ~bypass & ~reset;
  assign final_beat  = (state_q == DRAIN) & (outstanding == 2'd1);
  assign rdata_last  = rdata_valid & final_beat;

  always_comb begin
    rdata = '0;
    if (fifo_cnt_q != 2'd0)
      rdata = fifo_mem[fifo_rd_q];
    else if (inflight_q)
      rdata = vrf_data_r;
  end

  assign vrf_en         = wr_hs | rd_issue;
  assign vrf_we         = wr_hs;
  assign vrf_addr       = addr_q;
  assign vrf_write_mask = wr_hs ? mask_q : '0;
  assign vrf_data_w     = wr_hs ? wdata : '0;
  assign done           = done_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    mask_d   = mask_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd_count == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d   = cmd_base;
            remain_d = cmd_count;
            mask_d   = cmd_mask;
            state_d  = cmd_we ? WRITE : READ;
          end
        end
      end
      WRITE: begin
        if (wr_hs) begin
          addr_d   = addr_inc;
          remain_d = remain_q - (AW+1)'(1);
          if (remain_q == (AW+1)'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        if (rd_issue) begin
          addr_d   = addr_inc;
          remain_d = remain_q - (AW+1)'(1);
          if (remain_q == (AW+1)'(1))
            state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && final_beat) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      mask_q     <= '0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      fifo_wr_q  <= 1'b0;
      fifo_rd_q  <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      mask_q     <= mask_d;
      done_q     <= done_d;
      inflight_q <= rd_issue;
      if (push)
        fifo_wr_q <= ~fifo_wr_q;
      if (pop_fifo)
        fifo_rd_q <= ~fifo_rd_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop_fifo};
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[fifo_wr_q] <= vrf_data_r;
  end

endmodule

// File: tb/tb_vrf_stream_ctrl.sv
// Randomized bench for vrf_stream_ctrl: a register-file model answers the DUT
// and a reference memory predicts every access and every read beat.
module tb_vrf_stream_ctrl;
  localparam int NUM_ELEMS = 8;
  localparam int ELEM_SIZE = 16;
  localparam int EPE       = 4;
  localparam int VRF_SIZE  = 32;
  localparam int AW        = 5;
  localparam int DW        = NUM_ELEMS * ELEM_SIZE;
  localparam int MW        = NUM_ELEMS * EPE;
  localparam int LANE_W    = ELEM_SIZE / EPE;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_base;
  logic [AW:0]   cmd_count;
  logic [MW-1:0] cmd_mask;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata;
  logic          rdata_valid, rdata_ready, rdata_last;
  logic [DW-1:0] rdata;
  logic          done, vrf_en, vrf_we;
  logic [AW-1:0] vrf_addr;
  logic [MW-1:0] vrf_write_mask;
  logic [DW-1:0] vrf_data_w, vrf_data_r;

  logic [DW-1:0] vrf_mem [VRF_SIZE];
  logic [DW-1:0] ref_mem [VRF_SIZE];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  vrf_stream_ctrl dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_base(cmd_base), .cmd_count(cmd_count), .cmd_mask(cmd_mask),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .rdata_last(rdata_last), .done(done),
    .vrf_en(vrf_en), .vrf_we(vrf_we), .vrf_addr(vrf_addr),
    .vrf_write_mask(vrf_write_mask), .vrf_data_w(vrf_data_w), .vrf_data_r(vrf_data_r)
  );

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < MW; b++)
      if (m[b]) r[b*LANE_W +: LANE_W] = new_w[b*LANE_W +: LANE_W];
    return r;
  endfunction

  // Register file: masked writes, read data one cycle after the access,
  // garbage on the read bus in every other cycle.
  always @(posedge clk) begin
    if (vrf_en && vrf_we)
      vrf_mem[vrf_addr] <= merge(vrf_mem[vrf_addr], vrf_data_w, vrf_write_mask);
    if (vrf_en && !vrf_we)
      vrf_data_r <= vrf_mem[vrf_addr];
    else
      vrf_data_r <= rand_word();
  end

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      cmd_valid   = 1'b0;
      wdata_valid = 1'($urandom_range(0, 1));
      wdata       = rand_word();
      rdata_ready = 1'($urandom_range(0, 1));
      #1;
      check_val("idle_wready", wdata_ready, 0);
      check_val("idle_en", vrf_en, 0);
      check_val("idle_rvalid", rdata_valid, 0);
      check_val("idle_crdy", cmd_ready, 1);
      check_val("idle_done", done, 0);
      @(negedge clk);
    end
  endtask

  task automatic send_cmd(input logic we, input logic [AW-1:0] base, input int count,
                          input logic [MW-1:0] mask);
    cmd_valid   = 1'b1;
    cmd_we      = we;
    cmd_base    = base;
    cmd_count   = (AW+1)'(count);
    cmd_mask    = mask;
    wdata_valid = 1'($urandom_range(0, 1));
    wdata       = rand_word();
    #1;
    check_val("cmd_ready", cmd_ready, 1);
    check_val("accept_en", vrf_en, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_we    = 1'($urandom_range(0, 1));
    cmd_base  = AW'($urandom);
    cmd_count = (AW+1)'($urandom);
    cmd_mask  = $urandom;
  endtask

  task automatic finish_burst();
    wdata_valid = 1'($urandom_range(0, 1));
    wdata       = rand_word();
    rdata_ready = 1'($urandom_range(0, 1));
    #1;
    check_val("done_pulse", done, 1);
    check_val("done_crdy", cmd_ready, 1);
    check_val("done_en", vrf_en, 0);
    check_val("done_rvalid", rdata_valid, 0);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [AW-1:0] base, input int count,
                          input logic [MW-1:0] mask, input int mode);
    logic [DW-1:0] beats[$];
    int i = 0;
    int cyc = 0;
    int a;
    send_cmd(1'b1, base, count, mask);
    for (int k = 0; k < count; k++) beats.push_back(rand_word());
    while (i < count && cyc < 400) begin
      cyc++;
      wdata_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      wdata       = wdata_valid ? beats[i] : rand_word();
      rdata_ready = 1'($urandom_range(0, 1));
      #1;
      check_val("w_crdy", cmd_ready, 0);
      check_val("w_wready", wdata_ready, 1);
      check_val("w_done", done, 0);
      if (wdata_valid) begin
        a = (int'(base) + i) % VRF_SIZE;
        check_val("w_en", vrf_en, 1);
        check_val("w_we", vrf_we, 1);
        check_val("w_addr", vrf_addr, a);
        check_val("w_data", vrf_data_w, beats[i]);
        check_val("w_mask", vrf_write_mask, mask);
        ref_mem[a] = merge(ref_mem[a], beats[i], mask);
        i++;
      end else begin
        check_val("w_idle_en", vrf_en, 0);
        check_val("w_idle_mask", vrf_write_mask, 0);
      end
      @(negedge clk);
    end
    if (i < count) check_val("w_timeout", 0, 1);
    if (mode == 0) check_val("w_cycles", cyc, count);
    finish_burst();
  endtask

  task automatic do_read(input logic [AW-1:0] base, input int count, input int mode,
                         input int abort_after);
    logic [DW-1:0] exp_q[$];
    int issued = 0;
    int got = 0;
    int cyc = 0;
    int first_valid = 0;
    for (int k = 0; k < count; k++) exp_q.push_back(ref_mem[(int'(base) + k) % VRF_SIZE]);
    send_cmd(1'b0, base, count, MW'($urandom));
    while (got < count && cyc < 400) begin
      cyc++;
      case (mode)
        0:       rdata_ready = 1'b1;
        1:       rdata_ready = cyc[0];
        default: rdata_ready = 1'($urandom_range(0, 1));
      endcase
      wdata_valid = 1'($urandom_range(0, 1));
      wdata       = rand_word();
      #1;
      check_val("r_crdy", cmd_ready, 0);
      check_val("r_wready", wdata_ready, 0);
      check_val("r_done", done, 0);
      if (vrf_en) begin
        check_val("r_we", vrf_we, 0);
        check_val("r_mask", vrf_write_mask, 0);
        check_val("r_addr", vrf_addr, (int'(base) + issued) % VRF_SIZE);
        check_val("r_throttle", (issued - got) <= 1, 1);
        check_val("r_overissue", issued < count, 1);
        issued++;
      end
      if (rdata_valid) begin
        if (first_valid == 0) first_valid = cyc;
        check_val("r_data", rdata, exp_q[got]);
        check_val("r_last", rdata_last, got == count - 1);
        if (rdata_ready) got++;
      end else begin
        check_val("r_last_idle", rdata_last, 0);
      end
      @(negedge clk);
      if (abort_after > 0 && got == abort_after) break;
    end
    if (count > 0) check_val("r_first_latency", first_valid, 2);
    if (abort_after > 0) begin
      reset       = 1'b1;
      rdata_ready = 1'b0;
      wdata_valid = 1'b0;
      #1;
      check_val("rst_no_access", vrf_en, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_val("rst_rvalid", rdata_valid, 0);
      check_val("rst_crdy", cmd_ready, 1);
      check_val("rst_en", vrf_en, 0);
      check_val("rst_done", done, 0);
      check_val("rst_addr", vrf_addr, 0);
      check_val("rst_rdata", rdata, 0);
      @(negedge clk);
      return;
    end
    if (got < count) check_val("r_timeout", 0, 1);
    if (mode == 0 && count > 0) check_val("r_cycles", cyc, count + 1);
    finish_burst();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] old_w;
    int cnt;
    for (int a = 0; a < VRF_SIZE; a++) begin
      vrf_mem[a] = rand_word();
      ref_mem[a] = vrf_mem[a];
    end
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_base = '0; cmd_count = '0; cmd_mask = '0;
    wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("reset_crdy", cmd_ready, 1);
    check_val("reset_wready", wdata_ready, 0);
    check_val("reset_rvalid", rdata_valid, 0);
    check_val("reset_rlast", rdata_last, 0);
    check_val("reset_done", done, 0);
    check_val("reset_en", vrf_en, 0);
    check_val("reset_we", vrf_we, 0);
    check_val("reset_addr", vrf_addr, 0);
    check_val("reset_wmask", vrf_write_mask, 0);
    check_val("reset_wdata", vrf_data_w, 0);
    check_val("reset_rdata", rdata, 0);
    @(negedge clk);

    do_write(5'd3, 4, '1, 0);
    idle(1);
    do_read(5'd30, 4, 0, -1);
    idle(1);
    do_read(AW'($urandom), 8, 1, -1);
    old_w = ref_mem[10];
    do_write(5'd10, 2, 32'h0000_000F, 0);
    check_val("mask_upper", vrf_mem[10] >> 16, old_w >> 16);
    check_val("mask_elem0", vrf_mem[10], ref_mem[10]);
    do_write(5'd5, 0, '1, 0);
    do_read(5'd7, 0, 0, -1);
    idle(1);
    do_read(5'd12, 5, 0, 2);
    idle(4);

    for (int n = 0; n < 30; n++) begin
      cnt = ($urandom_range(0, 7) == 0) ? VRF_SIZE : int'($urandom_range(0, 10));
      if ($urandom_range(0, 1) == 1)
        do_write(AW'($urandom), cnt, MW'($urandom), int'($urandom_range(0, 1)));
      else
        do_read(AW'($urandom), cnt, int'($urandom_range(0, 2)), -1);
      idle(int'($urandom_range(0, 2)));
    end

    for (int a = 0; a < VRF_SIZE; a++) check_val("mem_final", vrf_mem[a], ref_mem[a]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
